spi_master_tx: RTL
==================

# spi_master_tx

Parameterised SPI mode-0 transmitter that serialises a parallel word onto `MOSI_o`/`SCK_o` and issues the one-cycle `slave_start_o` strobe that arms the downstream `spi_slave` receiver. It sits directly upstream of the slave in the same clock domain and drives its `MOSI_i`, `SCK_i` and `start_i` inputs. It generates SCK by dividing `clk_i`, with phases wide enough for the slave's two-flop SCK synchroniser to detect every edge.

## Interface
- `DATA_WIDTH`, 8: bits per transfer; must be >= 2.
- `CLK_DIV`, 4: SCK half-period in `clk_i` cycles; must be >= 4, otherwise elaboration fails via `$error`.

- `clk_i` input 1: system clock.
- `reset_i` input 1: reset, asynchronous, active-high.
- `data_i` input DATA_WIDTH: word to transmit, sampled only on acceptance.
- `start_i` input 1: transfer request; accepted only when `ready_o`=1.
- `ready_o` output 1: high only in IDLE.
- `slave_start_o` output 1: one-cycle strobe that arms the slave receiver.
- `MOSI_o` output 1: serial data, MSB first.
- `SCK_o` output 1: SPI clock, idle low, registered.
- `done_o` output 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, ARM, SHIFT, TRAIL, DONE; all outputs are registered except `ready_o`, which is decoded from state.
- IDLE: `SCK_o`=0, `MOSI_o`=0. When `start_i`=1, latch `data_i` into the shift register, load the bit counter with DATA_WIDTH, and go to ARM.
- ARM, one cycle: `slave_start_o`=1 and `MOSI_o`=shift[MSB]. Then clear the divider and go to SHIFT.
- SHIFT:
  - The divider counter ($clog2(CLK_DIV) bits) counts 0..CLK_DIV-1. On wrap, `SCK_o` toggles.
  - On a falling toggle (1->0), the shift register moves left one bit, `MOSI_o` takes the new MSB, and the bit counter decrements.
  - When the counter reaches 0 on that falling toggle, go to TRAIL and hold `MOSI_o`.
- TRAIL: hold `SCK_o`=0 for CLK_DIV cycles, then go to DONE.
- DONE, one cycle: `done_o`=1, then go to IDLE and set `MOSI_o`=0.
- Data changes only on SCK falling edges and is stable through each whole high phase. This guarantees the slave samples a stable bit even with its 2-3 cycle synchroniser delay.
- `start_i` outside IDLE is ignored and is not queued. Changes to `data_i` after acceptance have no effect.
- The bit counter is $clog2(DATA_WIDTH+1) bits wide. No arithmetic overflow is possible because the counter is reloaded on every acceptance.
- Reset at any time, including mid-transfer, immediately forces:
  - state=IDLE;
  - `SCK_o`=0, `MOSI_o`=0, `slave_start_o`=0, `done_o`=0;
  - `ready_o`=1;
  - shift register and counters cleared.
  
  No partial SCK pulse follows reset release.

## Timing
- Reset values: `ready_o`=1, `SCK_o`=0, `MOSI_o`=0, `slave_start_o`=0, `done_o`=0.
- Acceptance at the rising edge ending cycle T, where `start_i`=1 and `ready_o`=1:
  - ARM in cycle T+1.
  - SHIFT begins in cycle T+2.
- For bit k (k=0 is the MSB):
  - SCK rises, first high cycle at T+2+(2k+1)·CLK_DIV.
  - SCK falls, first low cycle at T+2+(2k+2)·CLK_DIV.
  - `MOSI_o` is valid from the preceding falling edge, or from ARM for k=0.
- Last falling edge: T+2+2·DATA_WIDTH·CLK_DIV.
- `done_o` cycle: T+2+(2·DATA_WIDTH+1)·CLK_DIV. For the defaults this is T+70.
- `ready_o`=1 in the cycle after `done_o`. If `start_i` is still high, a new transfer is accepted in that same cycle, with no extra gap.
- `slave_start_o` precedes the first SCK rising edge by CLK_DIV+1 cycles, so the slave is in RECEIVING before it detects any edge.

## Test plan
- Single transfer, DATA_WIDTH=8, CLK_DIV=4, `data_i`=0xA5, looped into `spi_slave` -> exactly 8 SCK rising edges; `MOSI_o` sequence 1,0,1,0,0,1,0,1; slave `done_o` pulses and reports 0xA5; master `done_o` at T+70 with width 1.
- Cycle check of the same transfer -> `slave_start_o` high only at T+1; first SCK high at T+6; SCK period 8 cycles; `MOSI_o` changes only in cycles where `SCK_o` goes 1->0.
- `start_i` held high with `data_i`=0x3C then 0xFF -> two back-to-back transfers; second acceptance in the cycle after the first `done_o`; second serial stream all ones.
- `start_i` pulsed at T+20 during a transfer of 0x81 -> ignored; only one `done_o`; exactly 8 SCK rises.
- Assert `reset_i` at T+30 during 0xF0 -> all outputs at reset values the same cycle; after release, `SCK_o` stays low until a new start; new transfer of 0x0F completes correctly.
- DATA_WIDTH=16, CLK_DIV=5, `data_i`=0xBEEF, into a 16-bit slave -> 16 rising edges; `done_o` at T+2+33·5=T+167; slave receives 0xBEEF.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmitter: serialises data_i MSB first onto MOSI_o/SCK_o and
// strobes slave_start_o one cycle before shifting so the receiver is armed.
// Ports:
//   clk_i, reset_i (async, active-high)
//   data_i, start_i, ready_o : parallel word request/acceptance
//   slave_start_o            : one-cycle arm strobe for the receiver
//   MOSI_o, SCK_o            : serial data and clock (SCK idles low)
//   done_o                   : one-cycle completion pulse
module spi_master_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  start_i,
  output logic                  ready_o,
  output logic                  slave_start_o,
  output logic                  MOSI_o,
  output logic                  SCK_o,
  output logic                  done_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] TRAIL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Narrower SCK phases would let the receiver's synchroniser miss edges.
  if (CLK_DIV < 4) begin : g_bad_div
    $error("spi_master_tx: CLK_DIV must be >= 4");
  end
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("spi_master_tx: DATA_WIDTH must be >= 2");
  end

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_q, ss_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        if (start_i) begin
          shift_d = data_i;
          cnt_d   = CNT_LOAD;
          mosi_d  = data_i[DATA_WIDTH-1];
          ss_d    = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        mosi_d  = shift_q[DATA_WIDTH-1];
        div_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = ~sck_q;
          // Falling toggle: advance to the next bit.
          if (sck_q) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = TRAIL;
            end else begin
              mosi_d = shift_q[DATA_WIDTH-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        mosi_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      done_q  <= done_d;
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign slave_start_o = ss_q;
  assign MOSI_o        = mosi_q;
  assign SCK_o         = sck_q;
  assign done_o        = done_q;

endmodule
